bitstream_run_ctrl: RTL and testbench

BITSTREAM_RUN_CTRL -- requirements
Module: bitstream_run_ctrl

---
 rtl/bitstream_pkg.sv | 23 ++
 rtl/lfsr32.sv | 28 ++
 rtl/bitstream_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_bitstream_run_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream run controller: FSM state encoding,
// LFSR polynomial/seed and small helpers used by the top and the LFSR.
package bitstream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [31:0] LFSR_TAPS       = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET_SEED = 32'h0000_0001;

  // A single lane still needs a one-bit address port.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] s, input int unsigned k);
    return (k == 0) ? s : ((s << k) | (s >> (32 - k)));
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous reset, load and advance enable.
// A load takes priority over an advance in the same cycle.
module lfsr32
  import bitstream_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LFSR_RESET_SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 32'h0);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/bitstream_run_ctrl.sv
// Stochastic bitstream generator: per-lane magnitude/sign compared against a rotated LFSR
// for run_len cycles. Define BITSTREAM_RUN_CTRL_RESEED_EN to add a per-run seed input.
module bitstream_run_ctrl
  import bitstream_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned BITWIDTH     = 20,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  cfg_we,
  input  logic [addr_width(NUM_ELEMENTS)-1:0]   cfg_addr,
  input  logic [BITWIDTH-1:0]                   cfg_value,
  input  logic                                  cfg_neg,
  output logic                                  cfg_ready,
  input  logic                                  start,
  input  logic [LEN_WIDTH-1:0]                  run_len,
  input  logic                                  abort,
`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
  input  logic [31:0]                           seed,
`endif
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_ELEMENTS-1:0]               out_p,
  output logic [NUM_ELEMENTS-1:0]               out_m,
  output logic                                  out_valid
);

  localparam int unsigned AddrW = addr_width(NUM_ELEMENTS);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic [BITWIDTH-1:0]     r_value [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] r_neg;
  logic [NUM_ELEMENTS-1:0] w_mag;
  logic [31:0]             w_lfsr;
  logic [31:0]             w_seed;
  logic                    w_load;
  logic                    w_idle;
  logic                    w_run;

  assign w_idle = (r_state == StIdle);
  assign w_run  = (r_state == StRun);

`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
  assign w_load = start && w_idle;
  assign w_seed = (seed == 32'h0) ? LFSR_RESET_SEED : seed;
`else
  assign w_load = 1'b0;
  assign w_seed = LFSR_RESET_SEED;
`endif

  lfsr32 u_lfsr (
    .i_clk   (CLK),
    .i_rst   (nRST),
    .i_en    (w_run),
    .i_load  (w_load),
    .i_seed  (w_seed),
    .o_state (w_lfsr)
  );

  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (run_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (r_cnt == LEN_WIDTH'(1)) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_p     = '0;
    out_m     = '0;
    if (nRST) begin
      cfg_ready = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: cfg_ready = 1'b1;
        StRun: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          out_p     = w_mag & ~r_neg;
          out_m     = w_mag & r_neg;
        end
        StDone: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Remaining RUN cycles; StRun leaves when it reaches one.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_cnt <= '0;
    end else if (start && w_idle) begin
      r_cnt <= run_len;
    end else if (w_run) begin
      r_cnt <= r_cnt - LEN_WIDTH'(1);
    end
  end

  // Out-of-range addresses match no lane and are dropped.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        r_value[i] <= '0;
      end
      r_neg <= '0;
    end else if (cfg_we && w_idle) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (cfg_addr == AddrW'(i)) begin
          r_value[i] <= cfg_value;
          r_neg[i]   <= cfg_neg;
        end
      end
    end
  end

  always_comb begin
    w_mag = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      w_mag[i] = (BITWIDTH'(rotl32(w_lfsr, unsigned'((7 * i) % 32))) < r_value[i]);
    end
  end

endmodule

// File: tb/tb_bitstream_run_ctrl.sv
// Directed bench for bitstream_run_ctrl: reset, long statistical run, zero-length run, abort,
// mid-run reset, start+write collision and, with BITSTREAM_RUN_CTRL_RESEED_EN, reseeding.
module tb_bitstream_run_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [19:0] cfg_value;
  logic        cfg_neg;
  logic        cfg_ready;
  logic        start;
  logic [15:0] run_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  out_p;
  logic [3:0]  out_m;
  logic        out_valid;
`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
  logic [31:0] seed;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bitstream_run_ctrl #(
    .NUM_ELEMENTS (4),
    .BITWIDTH     (20),
    .LEN_WIDTH    (16)
  ) u_dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_value (cfg_value),
    .cfg_neg   (cfg_neg),
    .cfg_ready (cfg_ready),
    .start     (start),
    .run_len   (run_len),
    .abort     (abort),
`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
    .seed      (seed),
`endif
    .busy      (busy),
    .done      (done),
    .out_p     (out_p),
    .out_m     (out_m),
    .out_valid (out_valid)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [19:0] v, input logic n);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_value = v;
    cfg_neg   = n;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Idle-rail snapshot: all run outputs low, ready high.
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'h1);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_rails"}, 64'({out_p, out_m}), 64'h0);
  endtask

  logic [3:0] first_p [3];
  logic [3:0] first_m [3];
`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
  logic [7:0] strm_a [32];
  logic [7:0] strm_b [32];
`endif

  initial begin
    int n_valid, n_busy, n_done, done_at;
    int p0, m0, p1, m1, l2;

    nRST = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_value = '0; cfg_neg = 1'b0;
    start = 1'b0; run_len = '0; abort = 1'b0;
`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
    seed = 32'h1;
`endif

    // Reset state
    repeat (3) tick();
    chk_idle("in_reset");
    nRST = 1'b0;
    tick();
    chk_idle("after_reset");

    // Long run: lane0 +2^19, lane1 -2^18, lane2 zero (neg), lane3 +2
    cfg_write(2'd0, 20'h80000, 1'b0);
    cfg_write(2'd1, 20'h40000, 1'b1);
    cfg_write(2'd2, 20'h00000, 1'b1);
    cfg_write(2'd3, 20'h00002, 1'b0);
    start = 1'b1; run_len = 16'd4096;
    tick();
    start = 1'b0;
    n_valid = 0; n_busy = 0; n_done = 0; done_at = -1;
    p0 = 0; m0 = 0; p1 = 0; m1 = 0; l2 = 0;
    for (int i = 0; i < 4100; i++) begin
      if (i < 3) begin
        first_p[i] = out_p;
        first_m[i] = out_m;
      end
      if (out_valid) n_valid++;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_at = i;
      end
      if (out_p[0]) p0++;
      if (out_m[0]) m0++;
      if (out_p[1]) p1++;
      if (out_m[1]) m1++;
      if (out_p[2] || out_m[2]) l2++;
      tick();
    end
    // LFSR states 1, 0x80200003, 0xC0300002 give these first three cycles
    chk("first_p0", 64'(first_p[0]), 64'h9);
    chk("first_m0", 64'(first_m[0]), 64'h2);
    chk("first_p1", 64'(first_p[1]), 64'h1);
    chk("first_m1", 64'(first_m[1]), 64'h2);
    chk("first_p2", 64'(first_p[2]), 64'h1);
    chk("first_m2", 64'(first_m[2]), 64'h2);
    chk("valid_count", 64'(n_valid), 64'd4096);
    chk("busy_count", 64'(n_busy), 64'd4097);
    chk("done_count", 64'(n_done), 64'd1);
    chk("done_at", 64'(done_at), 64'd4096);
    chk_range("lane0_p_ones", p0, 1843, 2253);
    chk("lane0_m_ones", 64'(m0), 64'd0);
    chk("lane1_p_ones", 64'(p1), 64'd0);
    chk_range("lane1_m_ones", m1, 819, 1229);
    chk("lane2_ones", 64'(l2), 64'd0);
    chk("ready_after_run", 64'(cfg_ready), 64'h1);

    // Zero-length run: one DONE cycle, no RUN
    start = 1'b1; run_len = 16'd0;
    tick();
    start = 1'b0;
    chk("zl_done", 64'(done), 64'h1);
    chk("zl_busy", 64'(busy), 64'h1);
    chk("zl_valid", 64'(out_valid), 64'h0);
    chk("zl_ready", 64'(cfg_ready), 64'h0);
    tick();
    chk_idle("zl_after");

    // Abort at RUN cycle 10 of 100; write during RUN must be dropped
    start = 1'b1; run_len = 16'd100;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("run_ready", 64'(cfg_ready), 64'h0);
    cfg_write(2'd0, 20'h00000, 1'b1);
    repeat (4) tick();
    chk("pre_abort_busy", 64'(busy), 64'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("post_abort");
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      tick();
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", 64'(cfg_ready), 64'h1);
    start = 1'b1; run_len = 16'd64;
    tick();
    start = 1'b0;
    p0 = 0; m0 = 0;
    for (int i = 0; i < 64; i++) begin
      if (out_p[0]) p0++;
      if (out_m[0]) m0++;
      tick();
    end
    chk_range("kept_lane0_p", p0, 8, 56);
    chk("kept_lane0_m", 64'(m0), 64'd0);
    tick();

    // Reset at RUN cycle 50
    start = 1'b1; run_len = 16'd100;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("pre_reset_valid", 64'(out_valid), 64'h1);
    nRST = 1'b1;
    tick();
    chk_idle("mid_reset");
    nRST = 1'b0;
    tick();

    // start and cfg_we at the same edge: first RUN cycle sees the new lane0
    start = 1'b1; run_len = 16'd1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_value = 20'hFFFFF; cfg_neg = 1'b0;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    chk("coll_p", 64'(out_p), 64'h1);
    chk("coll_m", 64'(out_m), 64'h0);
    chk("coll_valid", 64'(out_valid), 64'h1);
    tick();
    chk("coll_done", 64'(done), 64'h1);
    tick();
    chk_idle("coll_after");

`ifdef BITSTREAM_RUN_CTRL_RESEED_EN
    cfg_write(2'd0, 20'h80000, 1'b0);
    cfg_write(2'd1, 20'h40000, 1'b1);
    seed = 32'hACE1;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1; run_len = 16'd32;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (r == 0) strm_a[i] = {out_p, out_m};
        else strm_b[i] = {out_p, out_m};
        tick();
      end
      tick();
    end
    // State 0xACE1: lane0 44257 < 2^19, lane1 0x67080 >= 2^18
    chk("seed_first", 64'(strm_a[0]), 64'h10);
    n_done = 0;
    for (int i = 0; i < 32; i++) if (strm_a[i] !== strm_b[i]) n_done++;
    chk("seed_repeat_diffs", 64'(n_done), 64'd0);
    for (int r = 0; r < 2; r++) begin
      seed = (r == 0) ? 32'h0 : 32'h1;
      start = 1'b1; run_len = 16'd32;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (r == 0) strm_a[i] = {out_p, out_m};
        else strm_b[i] = {out_p, out_m};
        tick();
      end
      tick();
    end
    chk("seed0_first", 64'(strm_a[0]), 64'h12);
    n_done = 0;
    for (int i = 0; i < 32; i++) if (strm_a[i] !== strm_b[i]) n_done++;
    chk("seed0_vs_seed1_diffs", 64'(n_done), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
